// File: rtl/evt_pkg.sv
// rtl/evt_pkg.sv - shared state encoding, word layout and trailer format for evt_fifo_reader
package evt_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        DATA    = 2'd1,
        TRAILER = 2'd2
    } evt_state_e;

    localparam int          WORD_W         = 33;
    localparam int          MARK_BIT       = 32;
    localparam int          TRL_CNT_W      = 16;
    localparam logic [7:0]  TRL_ID_DEFAULT = 8'hEE;
    localparam logic [7:0]  TRL_RSV        = 8'h00;

    // Trailer layout: [31:24] id, [23:16] reserved, [15:0] payload word count.
    function automatic logic [31:0] trailer_word(input logic [7:0] id,
                                                 input logic [TRL_CNT_W-1:0] cnt);
        return {id, TRL_RSV, cnt};
    endfunction

endpackage

// File: rtl/evt_skid_buf.sv
// rtl/evt_skid_buf.sv - DEPTH x 33 word buffer with occupancy count and registered output stage
module evt_skid_buf
    import evt_pkg::*;
#(
    parameter  int DEPTH = 3,
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CNT_W = $clog2(DEPTH + 2)
) (
    input  logic              clk_i,
    input  logic              rst_n_i,
    input  logic              wr_en_i,
    input  logic [WORD_W-1:0] wr_data_i,
    input  logic              ins_en_i,
    input  logic [WORD_W-1:0] ins_data_i,
    input  logic              out_ready_i,
    output logic [WORD_W-1:0] out_data_o,
    output logic              out_valid_o,
    output logic              out_ins_o,
    output logic [CNT_W-1:0]  occ_o
);

    logic [WORD_W-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [WORD_W-1:0] out_q, out_d;
    logic              out_valid_q, out_valid_d, out_ins_q, out_ins_d;
    logic              load, pop, push, bypass;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    // Output register refills from an injected word first, then stored words,
    // then straight from the capture path so an empty buffer adds no latency.
    always_comb begin
        load        = !out_valid_q || out_ready_i;
        pop         = 1'b0;
        bypass      = 1'b0;
        out_d       = out_q;
        out_valid_d = out_valid_q;
        out_ins_d   = out_ins_q;
        if (load) begin
            out_valid_d = 1'b1;
            out_ins_d   = 1'b0;
            if (ins_en_i) begin
                out_d     = ins_data_i;
                out_ins_d = 1'b1;
            end else if (cnt_q != '0) begin
                out_d = mem_q[rd_ptr_q];
                pop   = 1'b1;
            end else if (wr_en_i) begin
                out_d  = wr_data_i;
                bypass = 1'b1;
            end else begin
                out_valid_d = 1'b0;
            end
        end
        push     = wr_en_i && !bypass;
        rd_ptr_d = pop  ? ptr_inc(rd_ptr_q) : rd_ptr_q;
        wr_ptr_d = push ? ptr_inc(wr_ptr_q) : wr_ptr_q;
        cnt_d    = cnt_q + CNT_W'(push) - CNT_W'(pop);
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            rd_ptr_q    <= '0;
            wr_ptr_q    <= '0;
            cnt_q       <= '0;
            out_q       <= '0;
            out_valid_q <= 1'b0;
            out_ins_q   <= 1'b0;
        end else begin
            if (push) begin
                mem_q[wr_ptr_q] <= wr_data_i;
            end
            rd_ptr_q    <= rd_ptr_d;
            wr_ptr_q    <= wr_ptr_d;
            cnt_q       <= cnt_d;
            out_q       <= out_d;
            out_valid_q <= out_valid_d;
            out_ins_q   <= out_ins_d;
        end
    end

    assign out_data_o  = out_q;
    assign out_valid_o = out_valid_q;
    assign out_ins_o   = out_ins_q;
    // An injected trailer is not a FIFO word and does not consume buffer credit.
    assign occ_o       = cnt_q + CNT_W'(out_valid_q && !out_ins_q);

endmodule

// File: rtl/evt_fifo_reader.sv
// rtl/evt_fifo_reader.sv - drains the 33-bit event FIFO into a 32-bit valid/ready stream
// Optional trailer word per event: define EVT_FIFO_READER_TRAILER_EN.
module evt_fifo_reader
    import evt_pkg::*;
#(
    parameter int         BUF_DEPTH = 3,
    parameter logic [7:0] TRL_ID    = TRL_ID_DEFAULT
) (
    input  logic        clk_i,
    input  logic        rst_n_i,
    input  logic [32:0] fifo_data_i,
    input  logic        fifo_empty_i,
    output logic        fifo_re_o,
    output logic [31:0] dat_o,
    output logic        dat_last_o,
    output logic        dat_valid_o,
    input  logic        dat_ready_i,
    output logic [15:0] evt_cnt_o,
    output logic        busy_o
);

    localparam int OCC_W = $clog2(BUF_DEPTH + 2);

    evt_state_e           state_q, state_d;
    logic                 run_q, inflight_q;
    logic [TRL_CNT_W-1:0] wcnt_q, wcnt_d, wcnt_inc;
    logic [15:0]          evt_cnt_q, evt_cnt_d;
    logic                 busy_q, busy_d;
    logic [WORD_W-1:0]    buf_data, ins_data;
    logic                 buf_valid, buf_ins, ins_en;
    logic [OCC_W-1:0]     occ;
    logic                 xfer, mark, fifo_re;

    // Credit check counts the word already requested, so the buffer cannot overflow.
    assign fifo_re  = run_q && !fifo_empty_i &&
                      ((int'(occ) + int'(inflight_q)) < BUF_DEPTH);
    assign xfer     = buf_valid && dat_ready_i;
    assign mark     = buf_data[MARK_BIT] && !buf_ins;
    assign wcnt_inc = (wcnt_q == '1) ? wcnt_q : wcnt_q + 1'b1;
    assign ins_data = {1'b1, trailer_word(TRL_ID, wcnt_d)};

    always_comb begin
        state_d   = state_q;
        wcnt_d    = wcnt_q;
        evt_cnt_d = evt_cnt_q;
        busy_d    = busy_q;
        ins_en    = 1'b0;
`ifdef EVT_FIFO_READER_TRAILER_EN
        if (state_q == TRAILER) begin
            if (xfer) begin
                evt_cnt_d = evt_cnt_q + 16'd1;
                wcnt_d    = '0;
                busy_d    = 1'b0;
                state_d   = IDLE;
            end
        end else
`endif
        if (buf_valid) begin
            state_d = DATA;
            if (state_q == IDLE) begin
                wcnt_d = '0;
            end
            if (xfer) begin
                wcnt_d = (state_q == IDLE) ? TRL_CNT_W'(1) : wcnt_inc;
                busy_d = 1'b1;
                if (mark) begin
`ifdef EVT_FIFO_READER_TRAILER_EN
                    // Trailer replaces the marker word in the output register on this edge.
                    ins_en  = 1'b1;
                    state_d = TRAILER;
`else
                    evt_cnt_d = evt_cnt_q + 16'd1;
                    busy_d    = 1'b0;
                    state_d   = IDLE;
`endif
                end
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q    <= IDLE;
            run_q      <= 1'b0;
            inflight_q <= 1'b0;
            wcnt_q     <= '0;
            evt_cnt_q  <= '0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            run_q      <= 1'b1;
            inflight_q <= fifo_re;
            wcnt_q     <= wcnt_d;
            evt_cnt_q  <= evt_cnt_d;
            busy_q     <= busy_d;
        end
    end

    evt_skid_buf #(
        .DEPTH (BUF_DEPTH)
    ) u_skid (
        .clk_i       (clk_i),
        .rst_n_i     (rst_n_i),
        .wr_en_i     (inflight_q),
        .wr_data_i   (fifo_data_i),
        .ins_en_i    (ins_en),
        .ins_data_i  (ins_data),
        .out_ready_i (dat_ready_i),
        .out_data_o  (buf_data),
        .out_valid_o (buf_valid),
        .out_ins_o   (buf_ins),
        .occ_o       (occ)
    );

    assign fifo_re_o   = fifo_re;
    assign dat_o       = buf_data[31:0];
    assign dat_valid_o = buf_valid;
`ifdef EVT_FIFO_READER_TRAILER_EN
    assign dat_last_o  = buf_ins;
`else
    assign dat_last_o  = mark;
`endif
    assign evt_cnt_o   = evt_cnt_q;
    assign busy_o      = busy_q;

endmodule

// File: tb/tb_evt_fifo_reader.sv
// tb/tb_evt_fifo_reader.sv - randomized self-checking bench for evt_fifo_reader
module tb_evt_fifo_reader;

    localparam int DEPTH = 3;
`ifdef EVT_FIFO_READER_TRAILER_EN
    localparam bit TRL = 1'b1;
`else
    localparam bit TRL = 1'b0;
`endif

    typedef struct packed {
        logic        trl;
        logic        last;
        logic [31:0] data;
    } exp_t;

    logic        clk_i = 1'b0;
    logic        rst_n_i;
    logic [32:0] fifo_data_i;
    logic        fifo_empty_i;
    logic        fifo_re_o;
    logic [31:0] dat_o;
    logic        dat_last_o;
    logic        dat_valid_o;
    logic        dat_ready_i;
    logic [15:0] evt_cnt_o;
    logic        busy_o;

    evt_fifo_reader #(.BUF_DEPTH(DEPTH), .TRL_ID(8'hEE)) dut (
        .clk_i        (clk_i),
        .rst_n_i      (rst_n_i),
        .fifo_data_i  (fifo_data_i),
        .fifo_empty_i (fifo_empty_i),
        .fifo_re_o    (fifo_re_o),
        .dat_o        (dat_o),
        .dat_last_o   (dat_last_o),
        .dat_valid_o  (dat_valid_o),
        .dat_ready_i  (dat_ready_i),
        .evt_cnt_o    (evt_cnt_o),
        .busy_o       (busy_o)
    );

    always #5 clk_i = ~clk_i;

    logic [32:0] fq[$];
    logic [32:0] pend_q[$];
    exp_t        exp_q[$];
    int          n_vec, n_err, n_cyc, in_dut, first_re, first_v, last_x, n_xfer, rel;
    int          ready_mode;
    bit          stall_rnd, stall_now;
    logic [15:0] evt_model;
    logic        busy_model, prev_hold, prev_last;
    logic [31:0] prev_dat;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Event of len words; only the first keep words are visible in the FIFO now.
    task automatic add_event(input int len, input int keep);
        logic [31:0] w;
        exp_t        e;
        for (int i = 0; i < len; i++) begin
            w = $urandom;
            if (i < keep) fq.push_back({i == len - 1, w});
            else          pend_q.push_back({i == len - 1, w});
            e.trl  = 1'b0;
            e.last = !TRL && (i == len - 1);
            e.data = w;
            exp_q.push_back(e);
        end
        if (TRL) begin
            e.trl  = 1'b1;
            e.last = 1'b1;
            e.data = {8'hEE, 8'h00, (len > 65535) ? 16'hFFFF : 16'(len)};
            exp_q.push_back(e);
        end
        fifo_empty_i = stall_now || fq.size() == 0;
    endtask

    task automatic cycle();
        logic v, r, re, l;
        logic [31:0] d;
        exp_t e;
        @(negedge clk_i);
        n_cyc++;
        v = dat_valid_o; r = dat_ready_i; re = fifo_re_o; l = dat_last_o; d = dat_o;
        chk("evt_cnt", evt_cnt_o, evt_model);
        chk("busy", busy_o, busy_model);
        chk("occupancy", in_dut <= DEPTH, 1);
        if (re) chk("re_while_empty", fifo_empty_i, 0);
        if (prev_hold) begin
            chk("hold_valid", v, 1);
            chk("hold_dat", d, prev_dat);
            chk("hold_last", l, prev_last);
        end
        prev_hold = v && !r; prev_dat = d; prev_last = l;
        if (re && first_re < 0) first_re = n_cyc;
        if (v && first_v < 0) first_v = n_cyc;
        if (v && r) begin
            n_xfer++;
            last_x = n_cyc;
            if (exp_q.size() == 0) begin
                chk("spurious_word", exp_q.size(), 1);
            end else begin
                e = exp_q.pop_front();
                chk("dat", d, e.data);
                chk("last", l, e.last);
                if (!e.trl) in_dut--;
                if (e.last) begin
                    evt_model++;
                    busy_model = 1'b0;
                end else begin
                    busy_model = 1'b1;
                end
            end
        end
        @(posedge clk_i);
        #1;
        if (re && fq.size() > 0) begin
            fifo_data_i = fq.pop_front();
            in_dut++;
        end
        stall_now    = stall_rnd && ($urandom_range(0, 3) == 0);
        fifo_empty_i = stall_now || fq.size() == 0;
        case (ready_mode)
            0:       dat_ready_i = 1'b1;
            1:       dat_ready_i = ~dat_ready_i;
            2:       dat_ready_i = 1'($urandom_range(0, 1));
            default: dat_ready_i = 1'b0;
        endcase
    endtask

    task automatic drain(input int budget);
        int n = 0;
        while ((exp_q.size() != 0 || fq.size() != 0) && n < budget) begin
            cycle();
            n++;
        end
        chk("drain_left", exp_q.size(), 0);
        repeat (2) cycle();
    endtask

    task automatic rst_assert();
        #2 rst_n_i = 1'b0;
        #1;
        chk("rst_re", fifo_re_o, 0);
        chk("rst_valid", dat_valid_o, 0);
        chk("rst_dat", dat_o, 0);
        chk("rst_last", dat_last_o, 0);
        chk("rst_busy", busy_o, 0);
        chk("rst_evt", evt_cnt_o, 0);
        fq.delete(); pend_q.delete(); exp_q.delete();
        in_dut = 0; evt_model = '0; busy_model = 1'b0; prev_hold = 1'b0;
        fifo_empty_i = 1'b1;
        repeat (2) @(posedge clk_i);
        #1;
    endtask

    task automatic rst_release();
        rst_n_i = 1'b1;
        rel = n_cyc;
        first_re = -1; first_v = -1; n_xfer = 0;
    endtask

    initial begin
        rst_n_i = 1'b0; fifo_data_i = '0; fifo_empty_i = 1'b1; dat_ready_i = 1'b1;
        n_vec = 0; n_err = 0; n_cyc = 0; in_dut = 0; last_x = 0; rel = 0;
        first_re = -1; first_v = -1; n_xfer = 0;
        ready_mode = 0; stall_rnd = 1'b0; stall_now = 1'b0;
        evt_model = '0; busy_model = 1'b0; prev_hold = 1'b0; prev_last = 1'b0; prev_dat = '0;
        repeat (2) @(posedge clk_i);
        #1;

        // 4-word event preloaded before reset release
        rst_assert();
        add_event(4, 4);
        rst_release();
        drain(200);
        chk("t1_first_re_delay", first_re - (rel + 1), 1);
        chk("t1_evt_cnt", evt_cnt_o, 1);

        // 100 one-word events at full rate
        rst_assert();
        for (int i = 0; i < 100; i++) add_event(1, 1);
        rst_release();
        drain(1000);
        chk("t2_latency", first_v - first_re, 2);
        chk("t2_words", n_xfer, TRL ? 200 : 100);
        chk("t2_burst_cycles", last_x - first_v + 1, TRL ? 200 : 100);
        chk("t2_evt_cnt", evt_cnt_o, 100);

        // 10-word event with ready toggling every cycle
        ready_mode = 1;
        add_event(10, 10);
        drain(500);
        ready_mode = 0;
        dat_ready_i = 1'b1;

        // FIFO runs dry mid-event
        add_event(8, 4);
        repeat (10) cycle();
        repeat (5) begin
            cycle();
            chk("t4_gap_valid", dat_valid_o, 0);
            chk("t4_gap_busy", busy_o, 1);
        end
        while (pend_q.size() != 0) fq.push_back(pend_q.pop_front());
        fifo_empty_i = 1'b0;
        drain(200);

        // reset with two words buffered and one in flight, then a 3-word event
        ready_mode = 3;
        dat_ready_i = 1'b0;
        add_event(6, 6);
        repeat (3) cycle();
        chk("t5_words_in_dut", in_dut, 3);
        rst_assert();
        ready_mode = 0;
        dat_ready_i = 1'b1;
        rst_release();
        add_event(3, 3);
        drain(200);
        chk("t5_evt_cnt", evt_cnt_o, 1);

        // random lengths, random ready, random FIFO stalls
        ready_mode = 2;
        stall_rnd = 1'b1;
        for (int i = 0; i < 25; i++) begin
            int len;
            len = $urandom_range(1, 8);
            add_event(len, len);
        end
        drain(3000);
        stall_rnd = 1'b0;
        ready_mode = 0;
        chk("t7_evt_cnt", evt_cnt_o, 26);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/evt_fifo_reader.md
Name: evt_fifo_reader

Overview:
- Read side of the 33-bit event data FIFO (Altera scfifo, non-showahead, 1-cycle read latency).
- Drains FIFO words into a 32-bit valid/ready output stream toward the readout packer.
- Bit 32 of each FIFO word marks the last word of an event.
- Per event: counts words, optionally appends a trailer word, and counts completed events.

Parameters:
- BUF_DEPTH, 3, output skid-buffer entries; minimum 3 for full throughput with 1-cycle FIFO latency.
- TRL_ID, 8'hEE, bits [31:24] of the trailer word.

Ports:
- clk_i  in  1  system clock
- rst_n_i  in  1  asynchronous active-low reset
- fifo_data_i  in  33  FIFO q; [32]=end-of-event marker, [31:0]=payload
- fifo_empty_i  in  1  FIFO empty flag
- fifo_re_o  out  1  FIFO read request
- dat_o  out  32  output word
- dat_last_o  out  1  last word of event on output
- dat_valid_o  out  1  output word valid
- dat_ready_i  in  1  downstream accept
- evt_cnt_o  out  16  completed events, wraps 0xFFFF->0
- busy_o  out  1  event in progress (first word taken, final word not yet accepted)

Behaviour:
- Reset (rst_n_i=0, async): all registers clear; every output is 0, fifo_re_o included. Reset mid-event drops buffered and in-flight words; the FIFO is cleared separately by the system sclr.
- Run gating: a run flag sets on the first clk_i edge after reset release. fifo_re_o is forced 0 while the flag is clear.
- Read issue:
  - fifo_re_o = run & !fifo_empty_i & (occ + inflight < BUF_DEPTH).
  - inflight is a register equal to last cycle's fifo_re_o.
  - fifo_re_o has no combinational path from dat_ready_i.
- Capture: when inflight=1, fifo_data_i is written into the buffer that cycle. The buffer is a FIFO of 33-bit entries; the buffer never overflows.
- Output handshake:
  - A word transfers when dat_valid_o & dat_ready_i.
  - While dat_valid_o=1 and dat_ready_i=0, dat_o, dat_last_o and dat_valid_o hold stable.
  - dat_o, dat_last_o and dat_valid_o are registered.
- Throughput: with fifo_empty_i=0 and dat_ready_i=1 continuously, one word per cycle after startup. Latency from first fifo_re_o to first dat_valid_o is 2 cycles.
- State machine (states IDLE, DATA, TRAILER):
  - IDLE: no event open. On the first buffer word presented -> DATA; the word counter loads 1 on its transfer.
  - DATA: presents buffer words; the word counter increments on each transfer.
  - When a word with marker=1 transfers:
    - Trailer disabled: dat_last_o was 1 on that word, evt_cnt_o increments, go to IDLE.
    - Trailer enabled: dat_last_o was 0 on that word, go to TRAILER.
  - TRAILER: presents {TRL_ID, 8'h00, wcnt[15:0]} with dat_last_o=1. On transfer: evt_cnt_o increments, word counter clears, go to IDLE.
  - Reads into the buffer continue during TRAILER.
- Word counter: 16 bits, counts payload words including the marker word, saturates at 0xFFFF.
- Single-word event (marker on the first word): valid. Counter=1; IDLE->DATA->IDLE (or via TRAILER).
- Back-to-back events: the next event's first word may present the cycle after the previous final word transfers, with no bubble.
- Simultaneous capture and pop of the buffer in one cycle: occupancy unchanged.
- busy_o=1 from the first word's transfer until the final word (marker or trailer) transfers.

Optional Feature:
- Macro: EVT_FIFO_READER_TRAILER_EN.
- Defined: TRAILER state and trailer word exist; dat_last_o marks the trailer.
- Undefined: no TRAILER state; dat_last_o = buffered bit 32. Word count is still kept, for busy_o and debug.

Decomposition:
- Shared package evt_pkg holds:
  - state encoding (IDLE, DATA, TRAILER);
  - TRL_ID default;
  - marker bit index 32;
  - trailer field positions.
- One natural sub-module: evt_skid_buf, the BUF_DEPTH x 33 buffer with occupancy count and registered output stage.

Test Plan:
- Reset release, FIFO holds 4 words, last with marker, dat_ready_i=1 -> first fifo_re_o exactly 1 cycle after release; 4 data words then trailer 0xEE000004 with dat_last_o=1; evt_cnt_o=1.
- 100 one-word events preloaded, dat_ready_i=1 -> 200 output words (trailer on) in 200 consecutive cycles after 2-cycle startup; evt_cnt_o=100.
- Event of 10 words, dat_ready_i toggling 1/0 each cycle -> output held stable while not ready; fifo_re_o never causes occ+inflight>3; all 10 words in order, then trailer count 0x000A.
- FIFO goes empty mid-event for 5 cycles -> dat_valid_o drops; busy_o stays 1; event resumes; no words lost or duplicated.
- rst_n_i pulsed low while 2 words are buffered and 1 is in flight -> all outputs 0 immediately; busy_o=0; evt_cnt_o=0; nothing from the dropped words appears after release.
- Macro undefined, 3-word event -> 3 output words, dat_last_o=1 on the third, no trailer; evt_cnt_o=1.
